// File: rtl/div_pkg.sv
// Shared types and constants for the LEGv8 SDIV/UDIV divider.
package div_pkg;

  localparam int DIV_WIDTH = 64;

  localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG =
    {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit, trial-subtract.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_i < dvs_i always holds, so the top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/int_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
module int_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             dvd_neg;
  logic             dvs_neg;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dvd_d       = dvd_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    dvd_neg     = is_signed & dividend[WIDTH-1];
    dvs_neg     = is_signed & divisor[WIDTH-1];
    unique case (state_q)
      IDLE, DONE: begin
        state_d = start ? CALC : IDLE;
        if (start) begin
          dvd_d  = dividend;
          negq_d = dvd_neg ^ dvs_neg;
          negr_d = dvd_neg;
          quo_d  = dvd_neg ? '0 - dividend : dividend;
          dvs_d  = dvs_neg ? '0 - divisor : divisor;
          rem_d  = '0;
          cnt_d  = CW'(WIDTH - 1);
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        if (cnt_q == '0) state_d = FIX;
        else cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        // Modulo negation also yields MIN / -1 = MIN, remainder 0.
        quotient_d  = negq_q ? '0 - quo_q : quo_q;
        remainder_d = negr_q ? '0 - rem_q : rem_q;
        dbz_d       = (dvs_q == '0);
        if (dvs_q == '0) begin
          quotient_d  = '0;
          remainder_d = dvd_q;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider against an arithmetic reference model.
module tb_int_divider;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  int_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic void model(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         z
  );
    longint sa;
    longint sb;
    sa = a;
    sb = b;
    z = (b == '0);
    if (b == '0) begin
      q = '0;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == DIV_MOST_NEG && b == '1) begin
      q = DIV_MOST_NEG;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Caller sits at a negedge; returns at the negedge where done is seen.
  task automatic do_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    input  int           poke,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         z,
    output int           lat,
    output int           bcnt,
    output logic         both
  );
    bit fin;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clock);
    lat  = 0;
    bcnt = 0;
    both = 1'b0;
    fin  = 1'b0;
    while (!fin) begin
      @(negedge clock);
      start = (poke != 0) && (lat + 1 == poke);
      if (start) begin
        dividend  = {$urandom, $urandom};
        divisor   = W'($urandom_range(1, 50));
        is_signed = 1'($urandom_range(0, 1));
      end
      if (busy && done) both = 1'b1;
      if (done) fin = 1'b1;
      else if (lat > 200) begin
        fin = 1'b1;
        lat = -1;
      end else begin
        if (busy) bcnt++;
        @(posedge clock);
        lat++;
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000",
               {busy, done, div_by_zero});
    end
    checks++;
    if (quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset_results: got %h/%h required 0/0",
               quotient, remainder);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic;
    logic [W-1:0] q, r;
    logic z, both;
    int lat, bcnt;
    do_op(64'd100, 64'd7, 1'b0, 0, q, r, z, lat, bcnt, both);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (bcnt !== LAT) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d required %0d", bcnt, LAT);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL busy_done_overlap: got %b required 0", both);
    end
    checks++;
    if (q !== 64'd14 || r !== 64'd2 || z !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %0d r %0d z %b required 14 r 2 z 0",
               q, r, z);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got done %b busy %b required 0 0",
               done, busy);
    end
  endtask

  task automatic test_table;
    logic [W-1:0] ta [8];
    logic [W-1:0] tb [8];
    logic         ts [8];
    logic [W-1:0] q, r, eq, er;
    logic z, ez, both;
    int lat, bcnt;
    ta = '{-64'sd100, 64'd100, -64'sd100, 64'd5,
           DIV_MOST_NEG, '1, 64'd0, DIV_MOST_NEG};
    tb = '{64'd7, -64'sd7, -64'sd7, 64'd0,
           '1, 64'd1, 64'd9, 64'd0};
    ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      model(ta[i], tb[i], ts[i], eq, er, ez);
      do_op(ta[i], tb[i], ts[i], 0, q, r, z, lat, bcnt, both);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
        errors++;
        $display("FAIL table_%0d: got q %h r %h z %b required q %h r %h z %b",
                 i, q, r, z, eq, er, ez);
      end
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL table_%0d_latency: got %0d required %0d", i, lat, LAT);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] q, r;
    logic z, both;
    int lat, bcnt, extra;
    do_op(64'd100, 64'd7, 1'b0, 10, q, r, z, lat, bcnt, both);
    checks++;
    if (q !== 64'd14 || r !== 64'd2 || lat !== LAT) begin
      errors++;
      $display("FAIL ignore_start: got q %0d r %0d lat %0d required 14 2 %0d",
               q, r, lat, LAT);
    end
    extra = 0;
    repeat (80) begin
      @(negedge clock);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0 || quotient !== 64'd14) begin
      errors++;
      $display("FAIL ignore_start_extra: got %0d dones q %0d required 0 q 14",
               extra, quotient);
    end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] q, r;
    logic z, both;
    int lat, bcnt;
    dividend  = 64'd100;
    divisor   = 64'd7;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || quotient !== 64'd14) begin
      errors++;
      $display("FAIL mid_run_state: got busy %b q %0d required 1 14",
               busy, quotient);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 ||
        quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b q %h r %h required 000 0 0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_op(64'd9, 64'd3, 1'b0, 0, q, r, z, lat, bcnt, both);
    checks++;
    if (q !== 64'd3 || r !== 64'd0 || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset: got q %0d r %0d lat %0d required 3 0 %0d",
               q, r, lat, LAT);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r;
    logic z, both;
    int lat, bcnt;
    do_op(64'd100, 64'd7, 1'b0, 0, q, r, z, lat, bcnt, both);
    do_op(64'd9, 64'd3, 1'b0, 0, q, r, z, lat, bcnt, both);
    checks++;
    if (lat + 1 !== LAT + 1 || q !== 64'd3 || r !== 64'd0) begin
      errors++;
      $display("FAIL back_to_back: got %0d edges q %0d r %0d required %0d 3 0",
               lat + 1, q, r, LAT + 1);
    end
    @(negedge clock);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, z, ez, both;
    int lat, bcnt;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 20));
        1: b = -W'($urandom_range(1, 20));
        2: b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er, ez);
      do_op(a, b, s, 0, q, r, z, lat, bcnt, both);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== LAT) begin
        errors++;
        $display("FAIL rand_%0d: %h/%h s%b got %h %h %b %0d required %h %h %b %0d",
                 i, a, b, s, q, r, z, lat, eq, er, ez, LAT);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clock);
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_table;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
